// File: rtl/param_counter.sv
// param_counter: parametrised up/down counter with prescaler, wrap or
// saturate at the bounds 0..MAX_COUNT, synchronous clear/load, a
// combinational terminal-count flag, a registered wrap pulse and a
// sticky overflow flag.
module param_counter #(
  parameter int WIDTH     = 8,
  parameter int MAX_COUNT = 255,
  parameter int RESET_VAL = 0,
  parameter int PRESCALE  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] value,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  // Prescale counter is at least one bit wide so PRESCALE=1 still elaborates.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PC_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH:0]   MAX_X   = (WIDTH + 1)'(MAX_COUNT);
  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] RST_V   = WIDTH'(RESET_VAL);

  logic [PW-1:0]    pcnt;
  logic [PW-1:0]    pcnt_nxt;
  logic [WIDTH-1:0] val_nxt;
  logic             wrap_nxt;
  logic             ovf_evt;
  logic             step;
  logic             bound;
  logic [WIDTH:0]   sum_up;
  logic [WIDTH:0]   sum_dn;

  // Loaded values above the legal range are pinned to MAX_COUNT.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] vx;
    vx = {1'b0, v};
    return (vx > MAX_X) ? MAX_V : v;
  endfunction

  // Value taken at a boundary step: wrap to the opposite bound, or hold.
  function automatic logic [WIDTH-1:0] bound_next(input logic [WIDTH-1:0] v,
                                                  input logic up,
                                                  input logic sat);
    if (sat)     return v;
    else if (up) return '0;
    else         return MAX_V;
  endfunction

  // Internal arithmetic is one bit wider so overflow/borrow are visible.
  assign sum_up = {1'b0, value} + 1'b1;
  assign sum_dn = {1'b0, value} - 1'b1;
  assign bound  = up_dn ? (sum_up > MAX_X) : sum_dn[WIDTH];
  assign step   = en & (pcnt == PC_LAST);
  assign tc     = step & bound;

  // Next-state selection with priority clr > load > count step.
  always_comb begin
    val_nxt  = value;
    pcnt_nxt = pcnt;
    wrap_nxt = 1'b0;
    ovf_evt  = 1'b0;
    if (clr) begin
      val_nxt  = '0;
      pcnt_nxt = '0;
    end else if (load) begin
      val_nxt  = clamp_load(load_val);
      pcnt_nxt = '0;
    end else if (en) begin
      pcnt_nxt = step ? '0 : pcnt + 1'b1;
      if (step) begin
        if (bound) begin
          ovf_evt  = 1'b1;
          wrap_nxt = ~sat_mode;
          val_nxt  = bound_next(value, up_dn, sat_mode);
        end else begin
          val_nxt  = up_dn ? sum_up[WIDTH-1:0] : sum_dn[WIDTH-1:0];
        end
      end
    end
  end

  // State registers; reset drops any partial prescale immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= RST_V;
      pcnt  <= '0;
      wrap  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      value <= val_nxt;
      pcnt  <= pcnt_nxt;
      wrap  <= wrap_nxt;
      // A new overflow event outranks a simultaneous clear request.
      ovf   <= ovf_evt | (ovf & ~ovf_clr);
    end
  end

endmodule
